jk_cmd_sequencer: RTL
=====================

// Module: jk_cmd_sequencer
// PURPOSE
//  Upstream driver for the jk_ff stage. Buffers J/K commands in a small FIFO and drives j,k for one clock per command.
//  Reads back q/qbar and checks each result against the ideal JK truth table.
//  Flags mismatches as a pulse and as a sticky bit, so a faulty flip-flop stage is caught in-system.
// PARAMETERS
//  DEPTH  4  command FIFO depth; power of 2, >=2
//  ERR_W  8  width of err_count (only with JK_ERR_CNT_EN)
// PORTS
//  clk         in   1               single clock, all logic on posedge
//  reset       in   1               asynchronous, active-low; clears all state
//  cmd_valid   in   1               command offered
//  cmd         in   2               {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
//  cmd_ready   out  1               FIFO can accept (= fifo_count < DEPTH)
//  j           out  1               registered J to flip-flop
//  k           out  1               registered K to flip-flop
//  q_in        in   1               flip-flop q
//  qbar_in     in   1               flip-flop qbar
//  clr_err     in   1               clears sticky_err
//  busy        out  1               FSM not IDLE or FIFO non-empty
//  done        out  1               1-cycle pulse per checked command
//  mismatch    out  1               1-cycle pulse, coincident with done, on check failure
//  sticky_err  out  1               set by mismatch, cleared by clr_err
//  fifo_count  out  $clog2(DEPTH)+1 FIFO occupancy
//  err_count   out  ERR_W           saturating mismatch count (JK_ERR_CNT_EN only)
// BEHAVIOUR
//  Reset values:
//  - j=k=0; busy=done=mismatch=sticky_err=0; fifo_count=0; err_count=0; FSM=IDLE.
//  - cmd_ready=1 as soon as count=0.
//  Push: push on cmd_valid&&cmd_ready. When full, cmd_ready=0 even if a pop occurs in the same cycle. Push+pop on a non-full FIFO leaves the count unchanged.
//  Pointers: wrap modulo DEPTH; FIFO order preserved.
//  FSM: IDLE -> DRIVE -> CHECK -> (DRIVE if FIFO non-empty, else IDLE).
//  - IDLE: if FIFO non-empty, pop the head and load {j,k}<=cmd at the same edge. Next state DRIVE.
//  - DRIVE (1 cycle): j,k held; capture q_prev<=q_in. The flip-flop samples j,k at the end of DRIVE.
//  - CHECK (1 cycle): j,k<=0. Compare q_in against exp, and check qbar_in==~q_in.
//  - CHECK exit, FIFO non-empty: pop the next command and load j,k at the same edge (back-to-back). Throughput = 1 command per 2 clocks.
//  exp per command:
//  - 00 -> q_prev
//  - 01 -> 0
//  - 10 -> 1
//  - 11 -> ~q_prev
//  Latency: done/mismatch are registered and asserted in the cycle after CHECK. Command push to done = 4 clocks when idle and empty.
//  mismatch = (q_in!=exp) || (qbar_in==q_in), sampled in CHECK.
//  sticky_err: if clr_err and a new mismatch coincide, the mismatch wins (stays 1).
//  Reset mid-operation: asynchronous return to IDLE; FIFO flushed; j,k=0 immediately; no done pulse for the aborted command.
//  Never pop an empty FIFO. Inputs X during DRIVE/CHECK are not masked.
// CONFIGURATION
//  JK_ERR_CNT_EN defined:
//  - err_count port and logic present.
//  - +1 on each mismatch pulse, saturates at 2**ERR_W-1.
//  - Cleared by reset and by clr_err; clr_err with a simultaneous mismatch loads 1.
//  JK_ERR_CNT_EN undefined: err_count port and logic absent; all other behaviour identical.
// TESTING
//  Bench uses an ideal JK model (posedge, async clear) in place of the flip-flop stage.
//  1. Reset, push 10,11,11,01,00 back-to-back:
//     - j,k follow at 2-clock spacing; 5 done pulses.
//     - Model q: 1,0,1,0,0; mismatch never asserted.
//  2. Push 5 commands with DEPTH=4 and the FSM held busy: 5th push stalls (cmd_ready=0) until the first pop; fifo_count peaks at 4.
//  3. Model forced to ignore toggle, push 10 then 11:
//     - Second done carries mismatch=1; sticky_err=1.
//     - err_count=1 (JK_ERR_CNT_EN).
//  4. qbar_in stuck equal to q_in, push 10: mismatch=1 even though q_in=1.
//  5. Assert reset during DRIVE with 3 queued commands:
//     - j,k=0 at once; fifo_count=0; no done.
//     - After release, a new push is processed normally.
//  6. sticky_err=1, clr_err pulsed: sticky_err=0 next cycle. clr_err coincident with a mismatch: sticky_err stays 1.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers {j,k} commands in a small FIFO, drives each onto
// a downstream JK flip-flop for one clock, then checks the returned q/qbar
// against the ideal JK truth table and reports done/mismatch/sticky_err.
// Optional build macro JK_ERR_CNT_EN adds a saturating err_count output.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4
`ifdef JK_ERR_CNT_EN
  , parameter int ERR_W = 8
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd,
  output logic                     cmd_ready,
  output logic                     j,
  output logic                     k,
  input  logic                     q_in,
  input  logic                     qbar_in,
  input  logic                     clr_err,
  output logic                     busy,
  output logic                     done,
  output logic                     mismatch,
  output logic                     sticky_err,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef JK_ERR_CNT_EN
  , output logic [ERR_W-1:0]       err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    cur_cmd;
  logic          q_prev;
  logic          push;
  logic          pop;
  logic          exp_q;
  logic          chk_fail;

  // Handshake, pop decision, and the expected q for the command under check
  always_comb begin
    cmd_ready = (fifo_count < FULL_CNT);
    push      = cmd_valid && cmd_ready;
    pop       = ((state == IDLE) || (state == CHECK)) && (fifo_count != '0);
    busy      = (state != IDLE) || (fifo_count != '0);
    exp_q     = 1'b0;
    case (cur_cmd)
      2'b00:   exp_q = q_prev;
      2'b01:   exp_q = 1'b0;
      2'b10:   exp_q = 1'b1;
      default: exp_q = ~q_prev;
    endcase
    chk_fail  = (q_in != exp_q) || (qbar_in == q_in);
  end

  // Command storage; flushing is done through the pointers, so no reset here
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sequencer FSM: drive one command, then check the flip-flop result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      j          <= 1'b0;
      k          <= 1'b0;
      cur_cmd    <= 2'b00;
      q_prev     <= 1'b0;
      done       <= 1'b0;
      mismatch   <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      // clr_err is applied first so a same-cycle mismatch below overrides it
      if (clr_err) sticky_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {j, k}  <= mem[rd_ptr];
            cur_cmd <= mem[rd_ptr];
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          q_prev <= q_in;
          {j, k} <= 2'b00;
          state  <= CHECK;
        end
        CHECK: begin
          done     <= 1'b1;
          mismatch <= chk_fail;
          if (chk_fail) sticky_err <= 1'b1;
          if (pop) begin
            {j, k}  <= mem[rd_ptr];
            cur_cmd <= mem[rd_ptr];
            state   <= DRIVE;
          end else begin
            state   <= IDLE;
          end
        end
        default: begin
          {j, k} <= 2'b00;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef JK_ERR_CNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Saturating mismatch counter; a same-cycle clear and mismatch loads 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if ((state == CHECK) && chk_fail) begin
      if (clr_err)                   err_count <= ERR_W'(1);
      else if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
    end else if (clr_err) begin
      err_count <= '0;
    end
  end
`endif

endmodule
